uart_tx_fifo_top: RTL and testbench

Transmit half of the SoC UART peripheral: a write-side byte FIFO feeding an 8N1 serial shifter with a run-time baud divisor. The bus register block drives the data-write strobe and the control-register TX-enable bit, and reads the status-register full/empty flags. `uart_tx_o` goes to the pad.

---
 rtl/uart_pkg.sv | 6 +
 rtl/uart_tx_fifo.sv | 41 ++++
 rtl/uart_tx_fifo_top.sv | 122 ++++++++++++
 tb/tb_uart_tx_fifo_top.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit path
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;
  localparam int UART_TX_FIFO_DEPTH_DEF = 32;
  localparam int UART_DATA_W = 8;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous byte FIFO with occupancy-count full/empty flags
// Ports: i_clk, i_rst_n (async active-low), i_push/i_data (write side),
//        i_pop/o_data (read side, o_data shows the head entry), o_full, o_empty
module uart_tx_fifo #(
  parameter int DEPTH = 32,
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push, w_pop;
  // A push while full is dropped even if a pop happens in the same cycle
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = r_count == CW'(DEPTH);
  assign o_empty = r_count == '0;
  assign o_data  = r_mem[r_rd_ptr];
  always_ff @(posedge i_clk)
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(w_push);
      r_rd_ptr <= r_rd_ptr + AW'(w_pop);
      r_count  <= r_count + CW'(w_push) - CW'(w_pop);
    end
endmodule

// File: rtl/uart_tx_fifo_top.sv
// uart_tx_fifo_top: byte FIFO feeding an 8N1 serial shifter with run-time baud divisor
// Ports: clk_i, rstn_i (async active-low); UART_Kontrol_Yazmaci_tx_Active (TX enable);
//        UART_Veri_Yazma_Yazmaci_enable/_wdata (push strobe and byte); baud_div
//        (cycles per bit, 0 treated as 1, latched per frame); UART_Durum_Yazmaci_tx_full/
//        _tx_empty (FIFO status); uart_tx_o (serial line, idle high).
// Build option: define UART_TX_PARITY_EN for an 8E1 frame with an even-parity bit.
module uart_tx_fifo_top
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = UART_TX_FIFO_DEPTH_DEF
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   UART_Kontrol_Yazmaci_tx_Active,
  input  logic                   UART_Veri_Yazma_Yazmaci_enable,
  input  logic [15:0]            baud_div,
  input  logic [UART_DATA_W-1:0] UART_Veri_Yazma_Yazmaci_wdata,
  output logic                   UART_Durum_Yazmaci_tx_full,
  output logic                   UART_Durum_Yazmaci_tx_empty,
  output logic                   uart_tx_o
);
  uart_tx_state_t         r_state, w_state_nxt;
  logic [15:0]            r_baud_cnt, w_baud_nxt, r_div, w_div_nxt;
  logic [2:0]             r_bit_cnt, w_bit_nxt;
  logic [UART_DATA_W-1:0] r_shift, w_shift_nxt, w_fifo_data;
  logic                   r_tx, w_tx_nxt, w_pop, w_start, w_bit_end, w_load;
`ifdef UART_TX_PARITY_EN
  logic                   r_par, w_par_nxt;
`endif
  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .W(UART_DATA_W)) u_fifo (
    .i_clk   (clk_i),
    .i_rst_n (rstn_i),
    .i_push  (UART_Veri_Yazma_Yazmaci_enable),
    .i_data  (UART_Veri_Yazma_Yazmaci_wdata),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (UART_Durum_Yazmaci_tx_full),
    .o_empty (UART_Durum_Yazmaci_tx_empty)
  );
  assign w_start   = UART_Kontrol_Yazmaci_tx_Active && !UART_Durum_Yazmaci_tx_empty;
  assign w_bit_end = r_baud_cnt == r_div - 16'd1;
  // A new frame loads from IDLE or directly at the end of STOP, so frames run back-to-back
  assign w_load    = w_start && (r_state == IDLE || (r_state == STOP && w_bit_end));
  assign uart_tx_o = r_tx;
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud_cnt + 16'd1;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_div_nxt   = r_div;
    w_pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_par_nxt   = r_par;
`endif
    case (r_state)
      IDLE: w_baud_nxt = '0;
      START: if (w_bit_end) begin
        w_baud_nxt  = '0;
        w_bit_nxt   = '0;
        w_state_nxt = DATA;
      end
      DATA: if (w_bit_end) begin
        w_baud_nxt  = '0;
        w_bit_nxt   = r_bit_cnt + 3'd1;
        w_shift_nxt = r_shift >> 1;
`ifdef UART_TX_PARITY_EN
        if (r_bit_cnt == 3'd7) w_state_nxt = PARITY;
`else
        if (r_bit_cnt == 3'd7) w_state_nxt = STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (w_bit_end) begin
        w_baud_nxt  = '0;
        w_state_nxt = STOP;
      end
`endif
      STOP: if (w_bit_end) begin
        w_baud_nxt  = '0;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_load) begin
      w_pop       = 1'b1;
      w_state_nxt = START;
      w_baud_nxt  = '0;
      w_shift_nxt = w_fifo_data;
      w_div_nxt   = baud_div == 16'd0 ? 16'd1 : baud_div;
`ifdef UART_TX_PARITY_EN
      w_par_nxt   = ^w_fifo_data;
`endif
    end
    // Line level is registered from next-state values so the pad sees no decode glitches
    w_tx_nxt = w_state_nxt == START ? 1'b0 : w_state_nxt == DATA ? w_shift_nxt[0] : 1'b1;
`ifdef UART_TX_PARITY_EN
    if (w_state_nxt == PARITY) w_tx_nxt = w_par_nxt;
`endif
  end
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      r_state    <= IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_div      <= '0;
      r_tx       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_par      <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_baud_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_div      <= w_div_nxt;
      r_tx       <= w_tx_nxt;
`ifdef UART_TX_PARITY_EN
      r_par      <= w_par_nxt;
`endif
    end
endmodule

// File: tb/tb_uart_tx_fifo_top.sv
// tb_uart_tx_fifo_top: directed self-checking bench for uart_tx_fifo_top
module tb_uart_tx_fifo_top;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        active = 1'b0;
  logic        wen = 1'b0;
  logic [15:0] div = 16'd4;
  logic [7:0]  wdata = 8'h00;
  logic        full, empty, tx;
  int          total = 0;
  int          bad = 0;

  uart_tx_fifo_top dut (
    .clk_i                          (clk),
    .rstn_i                         (rstn),
    .UART_Kontrol_Yazmaci_tx_Active (active),
    .UART_Veri_Yazma_Yazmaci_enable (wen),
    .baud_div                       (div),
    .UART_Veri_Yazma_Yazmaci_wdata  (wdata),
    .UART_Durum_Yazmaci_tx_full     (full),
    .UART_Durum_Yazmaci_tx_empty    (empty),
    .uart_tx_o                      (tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wen = 1'b1;
    wdata = d;
    step();
    wen = 1'b0;
  endtask

  // Checks one frame sample-by-sample, starting one tick after the popping edge.
  task automatic check_frame(input logic [7:0] d, input int bdiv, input int drop_cyc,
                             input int chg_cyc, input logic [15:0] chg_val);
    logic [10:0] bits;
    int n;
`ifdef UART_TX_PARITY_EN
    bits = {1'b1, ^d, d, 1'b0};
    n = 11;
`else
    bits = {2'b11, d, 1'b0};
    n = 10;
`endif
    for (int i = 0; i < n; i++)
      for (int c = 0; c < bdiv; c++) begin
        if (i * bdiv + c == drop_cyc) active = 1'b0;
        if (i * bdiv + c == chg_cyc) div = chg_val;
        chk($sformatf("frame_%02h_bit%0d_cyc%0d", d, i, c), {31'd0, tx}, {31'd0, bits[i]});
        step();
      end
  endtask

  initial begin
    step();
    step();
    chk("reset_tx", {31'd0, tx}, 32'd1);
    chk("reset_empty", {31'd0, empty}, 32'd1);
    chk("reset_full", {31'd0, full}, 32'd0);
    rstn = 1'b1;
    active = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      chk("idle_tx", {31'd0, tx}, 32'd1);
    end

    push(8'hA5);
    chk("single_empty_after_push", {31'd0, empty}, 32'd0);
    step();
    chk("single_empty_after_pop", {31'd0, empty}, 32'd1);
    check_frame(8'hA5, 4, -1, -1, 16'd0);
    chk("single_tx_after", {31'd0, tx}, 32'd1);
    chk("single_empty_after", {31'd0, empty}, 32'd1);

    // Back-to-back frames; divisor change mid-frame only affects the following frame
    push(8'h00);
    push(8'hFF);
    check_frame(8'h00, 4, -1, 10, 16'd2);
    check_frame(8'hFF, 2, -1, -1, 16'd0);
    chk("b2b_tx_after", {31'd0, tx}, 32'd1);
    div = 16'd4;
    step();

    // Gating: drop enable during D3 of the first of two frames
    push(8'h3C);
    push(8'hC3);
    check_frame(8'h3C, 4, 17, -1, 16'd0);
    for (int i = 0; i < 20; i++) begin
      chk("gate_idle_tx", {31'd0, tx}, 32'd1);
      chk("gate_empty", {31'd0, empty}, 32'd0);
      step();
    end
    active = 1'b1;
    step();
    check_frame(8'hC3, 4, -1, -1, 16'd0);
    chk("gate_empty_after", {31'd0, empty}, 32'd1);

    // Overflow: 33 pushes with TX disabled, last one dropped
    active = 1'b0;
    for (int i = 0; i < 33; i++) begin
      push(8'(i));
      if (i == 30) chk("ovf_full_at31", {31'd0, full}, 32'd0);
      if (i >= 31) chk($sformatf("ovf_full_at%0d", i + 1), {31'd0, full}, 32'd1);
    end
    chk("ovf_tx_held", {31'd0, tx}, 32'd1);
    active = 1'b1;
    step();
    chk("ovf_full_clears", {31'd0, full}, 32'd0);
    for (int i = 0; i < 32; i++) check_frame(8'(i), 4, -1, -1, 16'd0);
    chk("ovf_empty_after", {31'd0, empty}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("ovf_no_extra", {31'd0, tx}, 32'd1);
      step();
    end

    // Divisor 0 behaves as 1
    div = 16'd0;
    push(8'h07);
    step();
    check_frame(8'h07, 1, -1, -1, 16'd0);
    chk("div0_tx_after", {31'd0, tx}, 32'd1);
    chk("div0_empty_after", {31'd0, empty}, 32'd1);

    // Async reset mid-frame
    div = 16'd4;
    push(8'h11);
    push(8'h22);
    step();
    chk("arst_pre_tx", {31'd0, tx}, 32'd0);
    #2 rstn = 1'b0;
    #1;
    chk("arst_tx", {31'd0, tx}, 32'd1);
    chk("arst_empty", {31'd0, empty}, 32'd1);
    chk("arst_full", {31'd0, full}, 32'd0);
    step();
    #2 rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("arst_after_tx", {31'd0, tx}, 32'd1);
      chk("arst_after_empty", {31'd0, empty}, 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
